mac_accumulator: RTL and testbench

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_accumulator.sv | 115 +++++++++++
 tb/tb_mac_accumulator.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - two-stage unsigned multiply-accumulate with result hold
// A product register feeds an accumulator; the HOLD state presents the result until it is consumed.
module mac_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 24,
  parameter int SATURATE  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_last,
  input  logic                 clear,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_acc,
  output logic                 out_overflow
);

  localparam int PW = 2 * WIDTH;

  if (ACC_WIDTH < PW) begin : g_bad_acc_width
    $error("mac_accumulator: ACC_WIDTH must be at least 2*WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        p_q, p_d;
  logic                 p_valid_q, p_valid_d;
  logic                 p_last_q, p_last_d;
  logic                 fin_q, fin_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH:0]   sum;
  logic                 accept;

  // Ready drops while the final pair is in the pipe so nothing slips in behind it.
  assign in_ready     = rst_n && (state_q != S_HOLD) && !(p_valid_q && p_last_q) && !fin_q;
  assign accept       = in_valid && in_ready;
  assign sum          = {1'b0, acc_q} + (ACC_WIDTH+1)'(p_q);
  assign out_valid    = (state_q == S_HOLD);
  assign out_acc      = out_valid ? acc_q : '0;
  assign out_overflow = out_valid ? ovf_q : 1'b0;

  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    p_valid_d = 1'b0;
    p_last_d  = 1'b0;
    fin_d     = 1'b0;
    acc_d     = acc_q;
    ovf_d     = ovf_q;

    if (accept) begin
      p_d       = PW'(in_a) * PW'(in_b);
      p_valid_d = 1'b1;
      p_last_d  = in_last;
    end

    case (state_q)
      S_IDLE, S_RUN: begin
        if (p_valid_q) begin
          // Once clamped, any further nonzero product carries again, so the clamp persists.
          if (sum[ACC_WIDTH] && (SATURATE != 0)) acc_d = '1;
          else                                   acc_d = sum[ACC_WIDTH-1:0];
          ovf_d = ovf_q | sum[ACC_WIDTH];
          fin_d = p_last_q;
        end
        if (accept && !in_last) state_d = S_RUN;
        if (fin_q)              state_d = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (clear) begin
      state_d   = S_IDLE;
      p_valid_d = 1'b0;
      p_last_d  = 1'b0;
      fin_d     = 1'b0;
      acc_d     = '0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      p_q       <= '0;
      p_valid_q <= 1'b0;
      p_last_q  <= 1'b0;
      fin_q     <= 1'b0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      p_valid_q <= p_valid_d;
      p_last_q  <= p_last_d;
      fin_q     <= fin_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - randomized self-checking bench for mac_accumulator
// Wrap and saturate instances share stimulus; expected sums come from plain integer arithmetic.
module tb_mac_accumulator;

  localparam int W  = 8;
  localparam int AW = 24;
  localparam longint MASK = 64'hFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          in_last = 1'b0;
  logic          clear = 1'b0;
  logic          out_ready = 1'b0;
  logic          r0, r1, v0, v1, ov0, ov1;
  logic [AW-1:0] acc0, acc1;

  int     checks = 0;
  int     failures = 0;
  longint m_sum;

  logic [1:0]    o_rdy_after, o_v1, o_v2, o_ov, o_rel_v, o_rel_rdy;
  logic [AW-1:0] o_acc0, o_acc1, o_rel_acc;

  always #5 clk = ~clk;

  mac_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .SATURATE(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .clear(clear), .out_valid(v0), .out_ready(out_ready),
    .out_acc(acc0), .out_overflow(ov0));

  mac_accumulator #(.WIDTH(W), .ACC_WIDTH(AW), .SATURATE(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r1), .in_a(in_a), .in_b(in_b),
    .in_last(in_last), .clear(clear), .out_valid(v1), .out_ready(out_ready),
    .out_acc(acc1), .out_overflow(ov1));

  function automatic longint e_wrap();
    return m_sum & MASK;
  endfunction
  function automatic longint e_sat();
    return (m_sum > MASK) ? MASK : m_sum;
  endfunction
  function automatic logic e_ovf();
    return m_sum > MASK;
  endfunction

  // Offer one pair at the falling edge, wait (bounded) for acceptance; the model sum grows on acceptance.
  task automatic feed(input int a, input int b, input bit last);
    int cnt = 0;
    in_valid = 1'b1; in_a = W'(a); in_b = W'(b); in_last = last;
    while (!r0 && cnt < 50) begin
      @(posedge clk); @(negedge clk); cnt++;
    end
    if (cnt >= 50) begin
      checks++; failures++;
      $display("FAIL feed_timeout in_ready stuck low a=%0d b=%0d", a, b);
    end
    @(posedge clk);
    m_sum += longint'(a) * longint'(b);
    @(negedge clk);
  endtask

  // Called right after the last pair's edge N: observe edges N+1 and N+2.
  task automatic collect();
    in_valid = 1'b0; in_last = 1'b0;
    o_rdy_after = {r0, r1};
    @(posedge clk); @(negedge clk);
    o_v1 = {v0, v1};
    @(posedge clk); @(negedge clk);
    o_v2 = {v0, v1}; o_ov = {ov0, ov1}; o_acc0 = acc0; o_acc1 = acc1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    o_rel_v = {v0, v1}; o_rel_rdy = {r0, r1}; o_rel_acc = acc0 | acc1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({r0, r1, v0, v1, ov0, ov1, acc0, acc1} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", {r0, r1, v0, v1, ov0, ov1, acc0, acc1});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({r0, r1} !== 2'b11) begin failures++; $display("FAIL reset_ready got=%b exp=11", {r0, r1}); end
    @(negedge clk);
  endtask

  task automatic test_async_reset_in_hold();
    m_sum = 0;
    feed(3, 4, 1'b1);
    collect();
    checks++;
    if (o_v2 !== 2'b11) begin failures++; $display("FAIL async_pre_valid got=%b exp=11", o_v2); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({r0, r1, v0, v1, ov0, ov1, acc0, acc1} !== '0) begin
      failures++; $display("FAIL async_reset_outputs got=%h exp=0", {r0, r1, v0, v1, ov0, ov1, acc0, acc1});
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({r0, r1, v0, v1} !== 4'b1100) begin failures++; $display("FAIL async_release got=%b exp=1100", {r0, r1, v0, v1}); end
    @(negedge clk);
  endtask

  task automatic test_stream();
    m_sum = 0;
    for (int i = 1; i <= 4; i++) feed(i, i, i == 4);
    collect();
    release_result();
    checks++;
    if ({o_rdy_after, o_v1, o_v2} !== 6'b000011) begin
      failures++; $display("FAIL stream_timing got=%b exp=000011", {o_rdy_after, o_v1, o_v2});
    end
    checks++;
    if (o_acc0 !== AW'(30) || o_acc1 !== AW'(30) || o_ov !== 2'b00) begin
      failures++; $display("FAIL stream_result got=%0d/%0d ovf=%b exp=30/30 ovf=00", o_acc0, o_acc1, o_ov);
    end
    checks++;
    if ({o_rel_v, o_rel_rdy} !== 4'b0011 || o_rel_acc !== '0) begin
      failures++; $display("FAIL stream_release got=%b acc=%0d exp=0011 acc=0", {o_rel_v, o_rel_rdy}, o_rel_acc);
    end
  endtask

  task automatic test_single_pairs();
    int a, b;
    for (int i = 0; i < 1500; i++) begin
      case (i)
        0: begin a = 0; b = 0; end
        1: begin a = 255; b = 255; end
        2: begin a = 0; b = 255; end
        3: begin a = 255; b = 1; end
        default: begin a = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255)); end
      endcase
      m_sum = 0;
      feed(a, b, 1'b1);
      collect();
      release_result();
      checks++;
      if ({o_v1, o_v2, o_rel_v, o_rel_rdy} !== 8'b00110011) begin
        failures++; $display("FAIL single_timing a=%0d b=%0d got=%b exp=00110011", a, b, {o_v1, o_v2, o_rel_v, o_rel_rdy});
      end
      checks++;
      if (o_acc0 !== AW'(a * b) || o_acc1 !== AW'(a * b) || o_ov !== 2'b00) begin
        failures++; $display("FAIL single_product a=%0d b=%0d got=%0d/%0d exp=%0d", a, b, o_acc0, o_acc1, a * b);
      end
    end
  endtask

  task automatic test_random_streams();
    int n, hold;
    for (int s = 0; s < 60; s++) begin
      m_sum = 0;
      n = int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) feed(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), i == n - 1);
      collect();
      hold = int'($urandom_range(0, 3));
      repeat (hold) begin @(posedge clk); @(negedge clk); end
      checks++;
      if ({o_v1, o_v2, v0, v1} !== 6'b001111 || acc0 !== o_acc0) begin
        failures++; $display("FAIL rstream_timing n=%0d got=%b acc=%0d exp=001111 acc=%0d", n, {o_v1, o_v2, v0, v1}, acc0, o_acc0);
      end
      checks++;
      if (longint'(o_acc0) !== e_wrap() || longint'(o_acc1) !== e_sat() || o_ov !== {2{e_ovf()}}) begin
        failures++; $display("FAIL rstream_result n=%0d got=%0d/%0d exp=%0d/%0d", n, o_acc0, o_acc1, e_wrap(), e_sat());
      end
      release_result();
    end
  endtask

  task automatic test_saturation();
    m_sum = 0;
    for (int i = 0; i < 300; i++) feed(255, 255, i == 299);
    collect();
    checks++;
    if (o_acc0 !== AW'(2730284) || longint'(o_acc0) !== e_wrap() || o_ov[1] !== 1'b1) begin
      failures++; $display("FAIL wrap_300 got=%0d ovf=%b exp=2730284 ovf=1", o_acc0, o_ov[1]);
    end
    checks++;
    if (o_acc1 !== AW'(16777215) || longint'(o_acc1) !== e_sat() || o_ov[0] !== 1'b1) begin
      failures++; $display("FAIL sat_300 got=%0d ovf=%b exp=16777215 ovf=1", o_acc1, o_ov[0]);
    end
    release_result();
    checks++;
    if ({o_rel_v, o_rel_rdy, ov0, ov1} !== 6'b001100 || o_rel_acc !== '0) begin
      failures++; $display("FAIL sat_release got=%b acc=%0d exp=001100 acc=0", {o_rel_v, o_rel_rdy, ov0, ov1}, o_rel_acc);
    end
  endtask

  task automatic test_backpressure();
    m_sum = 0;
    feed(7, 9, 1'b0);
    feed(6, 6, 1'b1);
    collect();
    in_valid = 1'b1; in_a = 8'd200; in_b = 8'd200; in_last = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({v0, v1, r0, r1} !== 4'b1100 || acc0 !== AW'(99) || acc1 !== AW'(99)) begin
        failures++; $display("FAIL bp_hold cycle=%0d got=%b acc=%0d exp=1100 acc=99", c, {v0, v1, r0, r1}, acc0);
      end
    end
    in_valid = 1'b0;
    release_result();
    checks++;
    if ({o_rel_v, o_rel_rdy} !== 4'b0011) begin failures++; $display("FAIL bp_release got=%b exp=0011", {o_rel_v, o_rel_rdy}); end
    m_sum = 0;
    feed(5, 5, 1'b1);
    collect();
    release_result();
    checks++;
    if (o_v2 !== 2'b11 || o_acc0 !== AW'(25) || o_acc1 !== AW'(25)) begin
      failures++; $display("FAIL bp_next got=%0d/%0d v=%b exp=25/25 v=11", o_acc0, o_acc1, o_v2);
    end
  endtask

  task automatic test_clear();
    m_sum = 0;
    for (int i = 0; i < 3; i++) feed(10, 10, 1'b0);
    in_a = 8'd7; in_b = 8'd7; in_last = 1'b1; clear = 1'b1;
    @(posedge clk); @(negedge clk);
    clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    checks++;
    if ({v0, v1, r0, r1} !== 4'b0011) begin failures++; $display("FAIL clear_state got=%b exp=0011", {v0, v1, r0, r1}); end
    repeat (3) begin @(posedge clk); @(negedge clk); end
    checks++;
    if ({v0, v1} !== 2'b00) begin failures++; $display("FAIL clear_discard got=%b exp=00", {v0, v1}); end
    m_sum = 0;
    feed(2, 3, 1'b1);
    collect();
    release_result();
    checks++;
    if (o_v2 !== 2'b11 || o_acc0 !== AW'(6) || o_acc1 !== AW'(6) || o_ov !== 2'b00) begin
      failures++; $display("FAIL clear_next got=%0d/%0d v=%b exp=6/6 v=11", o_acc0, o_acc1, o_v2);
    end
  endtask

  task automatic test_clear_vs_ready();
    m_sum = 0;
    feed(9, 9, 1'b1);
    collect();
    out_ready = 1'b1; clear = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0; clear = 1'b0;
    checks++;
    if ({v0, v1, r0, r1} !== 4'b0011 || (acc0 | acc1) !== '0) begin
      failures++; $display("FAIL clear_ready got=%b acc=%0d exp=0011 acc=0", {v0, v1, r0, r1}, acc0 | acc1);
    end
    m_sum = 0;
    feed(4, 4, 1'b1);
    collect();
    release_result();
    checks++;
    if (o_v2 !== 2'b11 || o_acc0 !== AW'(16) || o_acc1 !== AW'(16)) begin
      failures++; $display("FAIL clear_ready_next got=%0d/%0d exp=16/16", o_acc0, o_acc1);
    end
  endtask

  task automatic test_reset_midstream();
    m_sum = 0;
    feed(10, 10, 1'b0);
    feed(10, 10, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    m_sum = 0;
    feed(2, 3, 1'b1);
    collect();
    release_result();
    checks++;
    if (o_v2 !== 2'b11 || o_acc0 !== AW'(6) || o_acc1 !== AW'(6)) begin
      failures++; $display("FAIL reset_mid_result got=%0d/%0d exp=6/6", o_acc0, o_acc1);
    end
  endtask

  initial begin
    test_reset();
    test_async_reset_in_hold();
    test_stream();
    test_single_pairs();
    test_random_streams();
    test_saturation();
    test_backpressure();
    test_clear();
    test_clear_vs_ready();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
